// File: rtl/cmos_16_8bit_tx.sv
// 16-bit pixel stream to 8-bit DVP byte stream with self-generated vsync/href frame timing.
// Define CMOS_TX_LOW_BYTE_FIRST_EN to send pix_i[7:0] before pix_i[15:8].
module cmos_16_8bit_tx #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 144,
  parameter int V_BACK   = 20,
  parameter int VS_WIDTH = 8
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] pix_i,
  input  logic        pix_valid_i,
  output logic        pix_ready_o,
  output logic [7:0]  pdata_o,
  output logic        href_o,
  output logic        vsync_o,
  output logic        underflow_o
);

  localparam logic [11:0] LINE_LAST = 12'(2 * H_ACTIVE - 1);
  localparam logic [11:0] HB_LAST   = 12'(H_BLANK - 1);
  localparam logic [11:0] VS_LAST   = 12'(VS_WIDTH - 1);
  localparam logic [10:0] VB_LAST   = 11'((V_BACK > 0) ? V_BACK - 1 : 0);
  localparam logic [10:0] VA_LAST   = 11'(V_ACTIVE - 1);

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, HBLANK} state_t;

  state_t      state;
  logic [11:0] x_cnt;
  logic [10:0] y_cnt;
  logic        ph;
  logic        vb_half;
  logic [7:0]  second_p0;

  function automatic logic [7:0] first_byte(input logic [15:0] p);
`ifdef CMOS_TX_LOW_BYTE_FIRST_EN
    return p[7:0];
`else
    return p[15:8];
`endif
  endfunction

  function automatic logic [7:0] second_byte(input logic [15:0] p);
`ifdef CMOS_TX_LOW_BYTE_FIRST_EN
    return p[15:8];
`else
    return p[7:0];
`endif
  endfunction

  assign pix_ready_o = (state == ACTIVE) && !ph;

  // p0: second byte of the accepted pixel waits one cycle behind the first
  always_ff @(posedge pclk) begin
    if (pix_ready_o) second_p0 <= pix_valid_i ? second_byte(pix_i) : 8'h00;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      x_cnt       <= '0;
      y_cnt       <= '0;
      ph          <= 1'b0;
      vb_half     <= 1'b0;
      pdata_o     <= 8'h00;
      href_o      <= 1'b0;
      vsync_o     <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      href_o      <= (state == ACTIVE);
      vsync_o     <= (state == VSYNC);
      underflow_o <= pix_ready_o && !pix_valid_i;
      if (pix_ready_o)          pdata_o <= pix_valid_i ? first_byte(pix_i) : 8'h00;
      else if (state == ACTIVE) pdata_o <= second_p0;
      else                      pdata_o <= 8'h00;
      ph <= (state == ACTIVE) ? ~ph : 1'b0;

      unique case (state)
        IDLE: begin
          x_cnt   <= '0;
          y_cnt   <= '0;
          vb_half <= 1'b0;
          if (en) state <= VSYNC;
        end
        VSYNC: begin
          if (x_cnt == VS_LAST) begin
            x_cnt <= '0;
            y_cnt <= '0;
            state <= (V_BACK > 0) ? VBACK : ACTIVE;
          end else x_cnt <= x_cnt + 12'd1;
        end
        // A blank line is split in two halves so each fits the 12-bit x_cnt.
        VBACK: begin
          if (!vb_half) begin
            if (x_cnt == LINE_LAST) begin
              vb_half <= 1'b1;
              x_cnt   <= '0;
            end else x_cnt <= x_cnt + 12'd1;
          end else if (x_cnt == HB_LAST) begin
            vb_half <= 1'b0;
            x_cnt   <= '0;
            if (y_cnt == VB_LAST) begin
              y_cnt <= '0;
              state <= ACTIVE;
            end else y_cnt <= y_cnt + 11'd1;
          end else x_cnt <= x_cnt + 12'd1;
        end
        ACTIVE: begin
          if (x_cnt == LINE_LAST) begin
            x_cnt <= '0;
            state <= HBLANK;
          end else x_cnt <= x_cnt + 12'd1;
        end
        HBLANK: begin
          if (x_cnt == HB_LAST) begin
            x_cnt <= '0;
            if (y_cnt == VA_LAST) begin
              y_cnt <= '0;
              state <= en ? VSYNC : IDLE;
            end else begin
              y_cnt <= y_cnt + 11'd1;
              state <= ACTIVE;
            end
          end else x_cnt <= x_cnt + 12'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmos_16_8bit_tx.sv
// Directed bench for cmos_16_8bit_tx: byte scoreboard plus per-cycle traces checked against frame timing.
module tb_cmos_16_8bit_tx;

  logic        pclk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] pix_i;
  logic        pix_valid_i;
  logic        pix_ready_o;
  logic [7:0]  pdata_o;
  logic        href_o;
  logic        vsync_o;
  logic        underflow_o;

  cmos_16_8bit_tx #(
    .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(3), .V_BACK(1), .VS_WIDTH(2)
  ) dut (
    .pclk(pclk), .rst(rst), .en(en), .pix_i(pix_i), .pix_valid_i(pix_valid_i),
    .pix_ready_o(pix_ready_o), .pdata_o(pdata_o), .href_o(href_o),
    .vsync_o(vsync_o), .underflow_o(underflow_o)
  );

  always #5 pclk = ~pclk;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  q[$];
  logic [15:0] src;
  int          cyc;
  int          rdy_idx;
  int          drop_idx;
  logic        vs_tr[0:255];
  logic        hr_tr[0:255];
  logic        uf_tr[0:255];
  logic        rd_tr[0:255];
  logic [7:0]  pd_tr[0:255];

  function automatic logic [7:0] first_b(input logic [15:0] p);
`ifdef CMOS_TX_LOW_BYTE_FIRST_EN
    return p[7:0];
`else
    return p[15:8];
`endif
  endfunction

  function automatic logic [7:0] second_b(input logic [15:0] p);
`ifdef CMOS_TX_LOW_BYTE_FIRST_EN
    return p[15:8];
`else
    return p[7:0];
`endif
  endfunction

  // Byte i of the incrementing source 0x0102, 0x0304, ...
  function automatic logic [7:0] src_byte(input int i);
    logic [15:0] p;
    p = {8'(2 * (i / 2) + 1), 8'(2 * (i / 2) + 2)};
    return (i % 2 == 0) ? first_b(p) : second_b(p);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic rdy;
    logic uf_exp;
    rdy = pix_ready_o;
    pix_valid_i = 1'b1;
    if (rdy) begin
      pix_valid_i = (rdy_idx != drop_idx);
      if (pix_valid_i) begin
        q.push_back(first_b(src));
        q.push_back(second_b(src));
      end else begin
        q.push_back(8'h00);
        q.push_back(8'h00);
      end
      rdy_idx++;
    end
    uf_exp = rdy && !pix_valid_i;
    @(posedge pclk);
    #1;
    if (rdy && pix_valid_i) src = src + 16'h0202;
    pix_i = src;
    if (cyc < 256) begin
      vs_tr[cyc] = vsync_o;
      hr_tr[cyc] = href_o;
      uf_tr[cyc] = underflow_o;
      rd_tr[cyc] = rdy;
      pd_tr[cyc] = pdata_o;
    end
    chk("underflow", underflow_o, uf_exp);
    if (href_o) begin
      checks++;
      assert (q.size() > 0) else begin
        failures++;
        $error("FAIL sb_empty observed=href_high expected=queued_byte cyc=%0d", cyc);
      end
      if (q.size() > 0) chk("pdata_sb", pdata_o, q.pop_front());
    end else begin
      chk("pdata_blank", pdata_o, 8'h00);
    end
    cyc++;
  endtask

  task automatic do_reset(input logic [15:0] start);
    rst = 1'b1;
    en  = 1'b0;
    q.delete();
    @(posedge pclk);
    #1;
    rst      = 1'b0;
    cyc      = 0;
    rdy_idx  = 0;
    drop_idx = -1;
    src      = start;
    pix_i    = start;
  endtask

  initial begin
    int r, h, f, n, nz;
    rst = 1'b0; en = 1'b0; pix_valid_i = 1'b1; pix_i = 16'h0000;
    src = 16'h0; cyc = 0; rdy_idx = 0; drop_idx = -1;
    #2 rst = 1'b1;
    #2;
    chk("rst_pdata", pdata_o, 8'h00);
    chk("rst_href", href_o, 1'b0);
    chk("rst_vsync", vsync_o, 1'b0);
    chk("rst_underflow", underflow_o, 1'b0);
    chk("rst_ready", pix_ready_o, 1'b0);

    // Basic frame, back-to-back frames
    do_reset(16'h0102);
    en = 1'b1;
    repeat (90) tick();
    r = -1;
    for (int i = 0; i < 90; i++) if (r < 0 && vs_tr[i]) r = i;
    chk("vsync_first_cycle", r, 1);
    if (r < 0) r = 0;
    chk("vsync_hi0", vs_tr[r], 1'b1);
    chk("vsync_hi1", vs_tr[r+1], 1'b1);
    chk("vsync_lo", vs_tr[r+2], 1'b0);
    n = 0; for (int i = r + 2; i <= r + 12; i++) n += int'(hr_tr[i]);
    chk("vback_href_cnt", n, 0);
    n = 0; for (int i = r + 13; i <= r + 20; i++) n += int'(hr_tr[i]);
    chk("line1_href_cnt", n, 8);
    n = 0; for (int i = r + 21; i <= r + 23; i++) n += int'(hr_tr[i]);
    chk("hblank_href_cnt", n, 0);
    n = 0; for (int i = r + 24; i <= r + 31; i++) n += int'(hr_tr[i]);
    chk("line2_href_cnt", n, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("line1_byte%0d", i), pd_tr[r+13+i], src_byte(i));
    for (int i = 0; i < 8; i++) chk($sformatf("line2_byte%0d", i), pd_tr[r+24+i], src_byte(i + 8));
    chk("vsync_period_lo", vs_tr[r+34], 1'b0);
    chk("vsync_period_rise", vs_tr[r+35], 1'b1);
    n = 0; for (int i = r; i < r + 35; i++) n += int'(rd_tr[i]);
    chk("ready_per_frame", n, 8);
    n = 0; for (int i = r + 35; i < r + 70; i++) n += int'(rd_tr[i]);
    chk("ready_per_frame2", n, 8);

    // Underflow on the second pixel of line 1
    do_reset(16'h0102);
    drop_idx = 1;
    en = 1'b1;
    repeat (40) tick();
    h = -1;
    for (int i = 0; i < 40; i++) if (h < 0 && hr_tr[i]) h = i;
    chk("uf_href_found", (h >= 0), 1'b1);
    if (h < 0) h = 0;
    chk("uf_b0", pd_tr[h],   first_b(16'h0102));
    chk("uf_b1", pd_tr[h+1], second_b(16'h0102));
    chk("uf_b2", pd_tr[h+2], 8'h00);
    chk("uf_b3", pd_tr[h+3], 8'h00);
    chk("uf_b4", pd_tr[h+4], first_b(16'h0304));
    chk("uf_b5", pd_tr[h+5], second_b(16'h0304));
    chk("uf_b6", pd_tr[h+6], first_b(16'h0506));
    chk("uf_b7", pd_tr[h+7], second_b(16'h0506));
    chk("uf_on_3rd_href", uf_tr[h+2], 1'b1);
    n = 0; for (int i = 0; i < 40; i++) n += int'(uf_tr[i]);
    chk("uf_pulse_count", n, 1);

    // en dropped during the first active line
    do_reset(16'h0102);
    en = 1'b1;
    n = 0;
    while (!href_o && n < 50) begin tick(); n++; end
    chk("endrop_href_seen", href_o, 1'b1);
    en = 1'b0;
    repeat (60) tick();
    n = 0; for (int i = 0; i < cyc; i++) n += int'(hr_tr[i]);
    chk("endrop_href_total", n, 16);
    n = 0; for (int i = 1; i < cyc; i++) n += int'(vs_tr[i] && !vs_tr[i-1]);
    chk("endrop_vsync_rises", n, 1);
    nz = 0;
    for (int i = 40; i < cyc; i++)
      nz += int'(vs_tr[i] | hr_tr[i] | uf_tr[i] | rd_tr[i] | (pd_tr[i] != 8'h00));
    chk("endrop_idle_quiet", nz, 0);
    chk("endrop_ready_low", pix_ready_o, 1'b0);

    // Reset asserted mid-line
    do_reset(16'h0102);
    en = 1'b1;
    n = 0;
    while (!href_o && n < 50) begin tick(); n++; end
    repeat (3) tick();
    chk("midrst_href_before", href_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_pdata", pdata_o, 8'h00);
    chk("midrst_href", href_o, 1'b0);
    chk("midrst_vsync", vsync_o, 1'b0);
    chk("midrst_underflow", underflow_o, 1'b0);
    chk("midrst_ready", pix_ready_o, 1'b0);
    q.delete();
    @(posedge pclk);
    #1;
    rst = 1'b0; cyc = 0; rdy_idx = 0; src = 16'h0102; pix_i = src;
    repeat (20) tick();
    f = -1;
    for (int i = 0; i < 20; i++) if (f < 0 && (vs_tr[i] || hr_tr[i])) f = i;
    chk("midrst_event_found", (f >= 0), 1'b1);
    if (f < 0) f = 0;
    chk("midrst_first_is_vsync", vs_tr[f], 1'b1);
    chk("midrst_first_no_href", hr_tr[f], 1'b0);
    chk("midrst_vsync_hi1", vs_tr[f+1], 1'b1);
    chk("midrst_vsync_lo", vs_tr[f+2], 1'b0);

    // Byte order of a single pixel
    do_reset(16'hA1B2);
    en = 1'b1;
    repeat (20) tick();
    h = -1;
    for (int i = 0; i < 20; i++) if (h < 0 && hr_tr[i]) h = i;
    if (h < 0) h = 0;
`ifdef CMOS_TX_LOW_BYTE_FIRST_EN
    chk("order_first", pd_tr[h], 8'hB2);
    chk("order_second", pd_tr[h+1], 8'hA1);
`else
    chk("order_first", pd_tr[h], 8'hA1);
    chk("order_second", pd_tr[h+1], 8'hB2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmos_16_8bit_tx.md
# cmos_16_8bit_tx

Serializes a 16-bit pixel stream into an 8-bit DVP-style byte stream with self-generated frame timing (vsync, href). It is the transmit counterpart of the 8-to-16-bit camera packer: it emulates a CMOS sensor port for loopback tests and drives 8-bit parallel links from the pixel domain. The block pulls pixels from upstream with a valid/ready handshake, two output cycles per pixel, high byte first.

## Interface
- H_ACTIVE, 640: pixels per active line; range 1..2047.
- V_ACTIVE, 480: active lines per frame; range 1..2047.
- H_BLANK, 144: href-low cycles after each line; range 1..4095.
- V_BACK, 20: blank lines between vsync and the first active line; range 0..2047.
- VS_WIDTH, 8: vsync-high cycles per frame; range 1..4095.
- pclk  in  1  pixel/byte clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  run enable; sampled only at frame boundaries.
- pix_i  in  16  upstream pixel; [15:8] sent first.
- pix_valid_i  in  1  upstream pixel valid.
- pix_ready_o  out  1  pixel accepted this cycle if pix_valid_i is high.
- pdata_o  out  8  output byte, registered.
- href_o  out  1  line-active qualifier, registered.
- vsync_o  out  1  frame sync, active-high, registered.
- underflow_o  out  1  one-cycle pulse when a pixel slot found pix_valid_i low.

## Operation
- FSM states: IDLE, VSYNC, VBACK, ACTIVE, HBLANK.
- IDLE: all outputs low. If en=1, go to VSYNC next cycle.
- VSYNC: lasts VS_WIDTH cycles. Then VBACK if V_BACK>0, else ACTIVE.
- VBACK: V_BACK blank lines, each 2*H_ACTIVE+H_BLANK cycles, href low. Then ACTIVE.
- ACTIVE: 2*H_ACTIVE cycles, then HBLANK.
- HBLANK: H_BLANK cycles. Then ACTIVE if more lines remain. After the last line, go to VSYNC if en=1, else IDLE.
- Counters:
  - x_cnt is 12 bits and clears on every state change.
  - y_cnt is 11 bits and counts lines inside VBACK and inside ACTIVE/HBLANK.
  - A 1-bit byte phase ph clears on entry to ACTIVE and toggles each ACTIVE cycle.
- Handshake:
  - pix_ready_o = (state==ACTIVE && ph==0). It is combinational from registered state and independent of pix_valid_i.
  - Upstream may hold pix_valid_i high continuously.
- Byte path:
  - On an accept cycle, latch pix_i.
  - The following cycle, pdata_o = pix_i[15:8].
  - The cycle after that, pdata_o = pix_i[7:0].
- Underflow:
  - If pix_valid_i=0 while pix_ready_o=1, set underflow_o=1 for one cycle.
  - Both bytes of that slot are 0x00.
  - Timing is unaffected; there is no stall or retry.
- Output registers: href_o and vsync_o are registered copies of (state==ACTIVE) and (state==VSYNC). pdata_o is 0x00 whenever href_o=0.
- Disabling: en=0 mid-frame does not truncate the frame. The current frame completes exactly, then the block goes to IDLE.
- Reset mid-frame: all state and outputs return to reset values immediately. No partial line is resumed.

## Timing
- Reset values: pdata_o=0x00, href_o=0, vsync_o=0, underflow_o=0, pix_ready_o=0, state=IDLE, all counters 0.
- Output latency from state: 1 cycle. The first byte of a line appears with the first href_o=1 cycle.
- href_o stays high for exactly 2*H_ACTIVE consecutive cycles per line.
- vsync_o stays high for exactly VS_WIDTH cycles.
- Frame period: VS_WIDTH + (V_BACK+V_ACTIVE)*(2*H_ACTIVE+H_BLANK) cycles.
- Back-to-back frames: with en held high, the next vsync_o rise occurs exactly one frame period after the previous one.
- Underflow pulse: underflow_o is aligned with the high-byte cycle of the affected slot, i.e. one cycle after the ready cycle.

## Configuration
- Macro CMOS_TX_LOW_BYTE_FIRST_EN.
- Defined: pix_i[7:0] is sent in the first byte cycle and pix_i[15:8] in the second.
- Undefined (default): pix_i[15:8] is sent first, matching the receive packer ({first, second} = {hi, lo}).
- Timing, handshake and underflow behaviour are identical in both builds.

## Test plan
Unless stated otherwise, parameters are H_ACTIVE=4, V_ACTIVE=2, H_BLANK=3, V_BACK=1, VS_WIDTH=2, giving a frame period of 2+3*11=35 cycles.

- Reset then en=1 with an always-valid incrementing source 0x0102, 0x0304, …:
  - vsync_o is high for 2 cycles.
  - 11 blank cycles follow.
  - href_o is high for 8 cycles with bytes 01 02 03 04 05 06 07 08, then low for 3.
  - Line 2 carries bytes 09..10.
- en held high: vsync_o rises every 35 cycles, and pix_ready_o pulses exactly 8 times per frame.
- pix_valid_i forced low for the 2nd pixel of line 1:
  - Bytes are 01 02 00 00 03 04 05 06.
  - underflow_o pulses once, on the 3rd href_o cycle.
- en dropped during the first active line: the frame completes (2 lines), then all outputs stay 0 and pix_ready_o stays 0.
- rst asserted mid-line: outputs are 0 in the same cycle. After release with en=1, the first event is a vsync_o 2-cycle pulse.
- Build with CMOS_TX_LOW_BYTE_FIRST_EN and pixel 0xA1B2: href bytes are B2 then A1.
